imem_bank_sync: RTL
===================

// Module: imem_bank_sync
// PURPOSE
//  Parametrised synchronous instruction memory: next generation of the fetch-side memory bank.
//  Adds a registered read port with valid/ready handshake, a 2-entry output skid buffer,
//  a program-load write port, a hardware clear sequencer and out-of-range error flagging.
//  Sits between the PC/fetch stage (requester) and the decode stage (consumer).
// PARAMETERS
//  DATA_W  16   instruction word width (bits)
//  ADDR_W  8    address width
//  DEPTH   256  number of words implemented; must be <= 2**ADDR_W, >= 2
// PORTS
//  clk       in   1       single clock, rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  clr       in   1       pulse: start hardware clear of all DEPTH words to 0
//  busy      out  1       clear sequence in progress
//  ld_en     in   1       program-load write strobe
//  ld_addr   in   ADDR_W  load address
//  ld_data   in   DATA_W  load data
//  rd_req    in   1       read request from fetch stage
//  rd_addr   in   ADDR_W  read address
//  rd_gnt    out  1       request accepted this cycle (comb.)
//  rd_valid  out  1       rd_data/rd_err valid
//  rd_ready  in   1       consumer accepts the head entry
//  rd_data   out  DATA_W  instruction word
//  rd_err    out  1       head entry came from address >= DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): buffer flushed, rd_valid=0, rd_data=0, rd_err=0;
//    FSM enters CLEAR, cnt=0, busy=1. Memory array itself is not reset, only cleared by FSM.
//  - FSM IDLE/CLEAR. CLEAR writes 0 to mem[cnt] each cycle, cnt++; at cnt==DEPTH-1 write
//    last word, go IDLE next edge (busy high exactly DEPTH cycles). IDLE->CLEAR on clr.
//    clr during CLEAR: ignored (no restart).
//  - rd_gnt = !busy && (occupancy < 2). Accept on rd_req && rd_gnt; memory read registered,
//    entry pushed into buffer at the accepting edge; rd_valid high the following cycle
//    (latency 1). Entries returned strictly in request order.
//  - Pop on rd_valid && rd_ready. Push and pop in same cycle at occupancy 2 is NOT allowed
//    (rd_gnt=0 when full); at occupancy 1 push+pop keeps occupancy 1.
//  - rd_data/rd_err hold stable while rd_valid && !rd_ready. When empty, rd_data=0, rd_err=0.
//  - rd_addr >= DEPTH: entry carries rd_data=0, rd_err=1; no memory access.
//  - ld_en honoured only in IDLE; ld_addr >= DEPTH dropped silently. ld_en during CLEAR ignored.
//  - Same-cycle load and accepted read to same address: read returns OLD data (read-first).
//  - clr while entries buffered: buffered entries remain and drain normally; new requests
//    blocked by busy. Reset mid-operation discards all buffered entries and restarts CLEAR.
//  - Widths: cnt is ADDR_W+1 bits to avoid wrap at DEPTH==2**ADDR_W.
// STRUCTURE
//  - Package imem_pkg: default DATA_W/ADDR_W/DEPTH constants, state enum {IDLE, CLEAR},
//    entry typedef {data, err}.
//  - Sub-module imem_skid_buf: 2-entry in-order FIFO of entries (push/pop/occupancy);
//    top holds array, clear FSM, load/read muxing.
// TESTING
//  1 Reset release -> busy=1 for 256 cycles, rd_gnt=0; then read any addr -> rd_data=0x0000.
//  2 Load mem[3]=0x7280, read addr 3 with rd_ready=1 -> rd_valid next cycle, data 0x7280, err=0.
//  3 rd_ready=0, issue reads 0,1,2 back-to-back -> 2 granted, third rd_gnt=0; release ready ->
//    returns addr0 then addr1 in order, data stable while stalled.
//  4 DEPTH=200, read addr 250 -> rd_valid=1, rd_data=0, rd_err=1; ld to 250 leaves mem unchanged.
//  5 Same-cycle ld mem[5]=0xBEEF and read 5 (old 0x1234) -> returns 0x1234; reread -> 0xBEEF.
//  6 Two entries buffered, pulse clr -> entries drain intact, busy=1 256 cycles, reads blocked,
//    then all words read 0; assert rst_n=0 mid-drain -> rd_valid=0 immediately.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared defaults and types for the fetch-side instruction memory bank.
package imem_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 256;

  typedef enum logic {IDLE, CLEAR} state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  err;
  } entry_t;

endpackage

// File: rtl/imem_skid_buf.sv
// Two-entry in-order FIFO holding read results until the decode stage takes them.
module imem_skid_buf #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;
  logic         do_pop;
  logic         push_ok;

  // Pop is applied first so a simultaneous push lands in the slot the pop freed.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    occ_d   = occ_q;
    do_pop  = pop && (occ_q != 2'd0);
    push_ok = push && ((occ_q != 2'd2) || do_pop);
    if (do_pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (push_ok) begin
      if (occ_d == 2'd0) begin
        ent0_d = push_data;
      end else begin
        ent1_d = push_data;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data = (occ_q != 2'd0) ? ent0_q : '0;
  assign occ       = occ_q;

endmodule

// File: rtl/imem_bank_sync.sv
// Synchronous instruction memory with handshaked read port, skid buffer,
// program-load port and hardware clear sequencer.
module imem_bank_sync
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam int unsigned     MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_V  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W+1)'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rd_entry_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_in_range;
  logic              ld_in_range;
  logic              accept;
  logic              pop;
  rd_entry_t         push_ent;
  rd_entry_t         head_ent;
  logic [1:0]        occ;

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_V;
  assign ld_in_range = {1'b0, ld_addr} < DEPTH_V;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = MEM_AW'(cnt_q);
        if (cnt_q == LAST_V) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_V;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (ld_en && ld_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = MEM_AW'(ld_addr);
          mem_wdata = ld_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array is deliberately not reset; the clear sequencer owns its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read samples the array before this edge's write lands, giving read-first behaviour.
  always_comb begin
    push_ent = '0;
    if (rd_in_range) begin
      push_ent.data = mem_q[MEM_AW'(rd_addr)];
    end else begin
      push_ent.err = 1'b1;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign rd_gnt   = !busy && (occ != 2'd2);
  assign accept   = rd_req && rd_gnt;
  assign rd_valid = (occ != 2'd0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = head_ent.data;
  assign rd_err   = head_ent.err;

  imem_skid_buf #(
    .W($bits(rd_entry_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_ent),
    .pop       (pop),
    .head_data (head_ent),
    .occ       (occ)
  );

endmodule
